control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Multi-cycle successor to the combinational control unit. It steps each instruction through FETCH, DECODE, EXECUTE and an optional MEMORY wait state, and latches opcode and operand into an internal instruction register. Control strobes are driven only in the cycle where they apply, and RAM accesses stall on a ready handshake. It sits between the instruction ROM/PC and the datapath (register file, W register, ALU, RAM, I/O).

Parameters:
OPCODE_W, 5, opcode width; the defined encodings occupy the low 5 bits, and any upper bits must be 0 for a decode match.
OPERAND_W, 8, operand/immediate width.
REG_SEL_W, 3, register-select width, taken from operand[REG_SEL_W-1:0].
ALU_OP_W, 4, ALU operation width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr_opcode  in  OPCODE_W  opcode from ROM at the current PC
instr_operand  in  OPERAND_W  operand from ROM at the current PC
zeroF  in  1  ALU zero flag
carryF  in  1  ALU carry flag
mem_ready  in  1  RAM access complete
operand_q  out  OPERAND_W  latched operand, driven to the ROM/data mux
WREG_WE, WREG_RE, REG_WE  out  1 each  W-register and register-file strobes
REG_SEL  out  REG_SEL_W  register select
RAM_RE, RAM_WE, RAM_ADDR_EN  out  1 each  RAM strobes
ALU_OP  out  ALU_OP_W  ALU operation
ALU_EN  out  1  ALU result enable
PC_LOAD, PC_EN  out  1 each  PC load / PC increment
ROM_TO_DATABUS, IN_TO_DATABUS, OUT_EN  out  1 each  bus source and output strobes
HALT  out  1  halted status
ILLEGAL  out  1  sticky undefined-opcode flag

Behaviour:
- Reset and timing: clk with synchronous active-high rst. While rst is high: state=FETCH, IR=0, ILLEGAL=0, all outputs 0. rst overrides every state, including MEM and HALTED.
- Output decode: outputs are Moore-decoded from state and IR. Every strobe is 0 outside the state listed for it below.
- FETCH (1 cycle): latch instr_opcode and instr_operand into IR. Go to DECODE.
- DECODE (1 cycle): no strobes. Go to EXEC.
- EXEC (1 cycle) strobes by opcode:
  - NOP 00000: PC_EN only.
  - LOADI 00001: WREG_WE, ROM_TO_DATABUS, PC_EN.
  - MOV 00100: WREG_WE, PC_EN.
  - MOVW 00101: WREG_RE, REG_WE, PC_EN.
  - ALU 01xxx: WREG_WE, ALU_EN, PC_EN; ALU_OP = zero-extended IR opcode[2:0]. In all other states ALU_OP = 0.
  - JMP 10000: PC_LOAD, ROM_TO_DATABUS.
  - JZ 10001: flags are sampled combinationally in EXEC. If zeroF=1, PC_LOAD and ROM_TO_DATABUS; otherwise PC_EN.
  - JC 10010: same as JZ, using carryF.
  - HLT 10011: go to HALTED; no PC_EN.
  - IN 10100: WREG_WE, IN_TO_DATABUS, PC_EN.
  - OUT 10101: WREG_RE, OUT_EN, PC_EN.
  - LOADA 00010 / STORE 00011: RAM_ADDR_EN only, then go to MEM.
  - Any other opcode: behaves as NOP and sets ILLEGAL (sticky until rst).
  - Every EXEC case except LOADA/STORE and HLT returns to FETCH.
- REG_SEL = operand_q[REG_SEL_W-1:0] in all states.
- MEM (1 or more cycles): hold RAM_ADDR_EN.
  - LOADA asserts RAM_RE; STORE asserts RAM_WE and WREG_RE.
  - While mem_ready=0, stay in MEM with strobes held.
  - In the cycle mem_ready=1: LOADA also asserts WREG_WE; both assert PC_EN; next state is FETCH.
  - mem_ready sampled outside MEM is ignored.
- HALTED: HALT=1, all other strobes 0. Exits only on rst.
- Cycle counts: minimum 3 cycles per instruction; LOADA/STORE take 4 + wait cycles.
- IR is written only in FETCH. ROM inputs changing in other states have no effect.
- PC_EN and PC_LOAD are never both 1.

Optional Feature:
SINGLE_STEP_EN.
- Defined: adds input port step_req (1 bit) and output port stepped (1 bit). A new state STEP_WAIT is entered on every return to FETCH. The block leaves STEP_WAIT for FETCH on the cycle after step_req=1. stepped pulses for 1 cycle on each EXEC/MEM completion. HLT still enters HALTED.
- Undefined: neither port exists and the sequencer free-runs.

Test Plan:
1. rst=1 held for 2 cycles, then released with opcode=00001 and operand=8'h03 -> all outputs 0 during reset; WREG_WE=ROM_TO_DATABUS=PC_EN=1 in exactly cycle 3 after release; operand_q=8'h03.
2. JZ with zeroF=0 in EXEC -> PC_EN=1, PC_LOAD=0. Repeat with zeroF=1 -> PC_LOAD=1, PC_EN=0. Repeat both checks for JC using carryF.
3. LOADA with mem_ready held 0 for 3 MEM cycles, then 1 -> RAM_RE and RAM_ADDR_EN high for 4 MEM cycles; WREG_WE and PC_EN high only in the last; 7 cycles total.
4. ALU opcode 01101 -> ALU_OP=4'b0101, ALU_EN=WREG_WE=1 in EXEC only.
5. HLT, then 10 cycles of arbitrary ROM input -> HALT=1 and all strobes 0 throughout. Assert rst -> HALT=0, state=FETCH.
6. Opcode 11111 -> PC_EN=1 in EXEC, ILLEGAL=1 and staying 1 through subsequent NOPs until rst. Assert rst in the middle of a MEM wait -> all strobes 0 in the next cycle.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM control FSM with IR latch; optional SINGLE_STEP_EN adds step_req/stepped
module control_sequencer #(
    parameter int OPCODE_W  = 5,
    parameter int OPERAND_W = 8,
    parameter int REG_SEL_W = 3,
    parameter int ALU_OP_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPCODE_W-1:0]  instr_opcode,
    input  logic [OPERAND_W-1:0] instr_operand,
    input  logic                 zeroF,
    input  logic                 carryF,
    input  logic                 mem_ready,
`ifdef SINGLE_STEP_EN
    input  logic                 step_req,
    output logic                 stepped,
`endif
    output logic [OPERAND_W-1:0] operand_q,
    output logic                 WREG_WE,
    output logic                 WREG_RE,
    output logic                 REG_WE,
    output logic [REG_SEL_W-1:0] REG_SEL,
    output logic                 RAM_RE,
    output logic                 RAM_WE,
    output logic                 RAM_ADDR_EN,
    output logic [ALU_OP_W-1:0]  ALU_OP,
    output logic                 ALU_EN,
    output logic                 PC_LOAD,
    output logic                 PC_EN,
    output logic                 ROM_TO_DATABUS,
    output logic                 IN_TO_DATABUS,
    output logic                 OUT_EN,
    output logic                 HALT,
    output logic                 ILLEGAL
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALTED
`ifdef SINGLE_STEP_EN
        , S_STEP_WAIT
`endif
    } state_t;

    state_t               r_state;
    logic [OPCODE_W-1:0]  r_opcode;
    logic [OPERAND_W-1:0] r_operand;
    logic                 r_illegal;

    logic [4:0] w_op;
    logic w_ok, w_ex, w_mem, w_take, w_legal, w_done;
    logic w_nop, w_ldi, w_mov, w_movw, w_alu, w_jmp, w_jz, w_jc, w_hlt, w_in, w_out, w_loada, w_store;
    state_t w_ret;

    assign w_op    = r_opcode[4:0];
    assign w_ok    = (r_opcode >> 5) == '0;
    assign w_ex    = r_state == S_EXEC;
    assign w_mem   = r_state == S_MEM;
    assign w_nop   = w_ok && w_op == 5'b00000;
    assign w_ldi   = w_ok && w_op == 5'b00001;
    assign w_loada = w_ok && w_op == 5'b00010;
    assign w_store = w_ok && w_op == 5'b00011;
    assign w_mov   = w_ok && w_op == 5'b00100;
    assign w_movw  = w_ok && w_op == 5'b00101;
    assign w_alu   = w_ok && w_op[4:3] == 2'b01;
    assign w_jmp   = w_ok && w_op == 5'b10000;
    assign w_jz    = w_ok && w_op == 5'b10001;
    assign w_jc    = w_ok && w_op == 5'b10010;
    assign w_hlt   = w_ok && w_op == 5'b10011;
    assign w_in    = w_ok && w_op == 5'b10100;
    assign w_out   = w_ok && w_op == 5'b10101;
    assign w_legal = w_nop | w_ldi | w_loada | w_store | w_mov | w_movw | w_alu |
                     w_jmp | w_jz | w_jc | w_hlt | w_in | w_out;
    assign w_take  = w_jmp || (w_jz && zeroF) || (w_jc && carryF);
    assign w_done  = (w_ex && !w_hlt && !w_loada && !w_store) || (w_mem && mem_ready);
`ifdef SINGLE_STEP_EN
    assign w_ret   = S_STEP_WAIT;
`else
    assign w_ret   = S_FETCH;
`endif

    assign operand_q      = r_operand;
    assign REG_SEL        = r_operand[REG_SEL_W-1:0];
    assign ILLEGAL        = r_illegal;
    assign HALT           = r_state == S_HALTED;
    assign WREG_WE        = (w_ex && (w_ldi || w_mov || w_alu || w_in)) || (w_mem && w_loada && mem_ready);
    assign WREG_RE        = (w_ex && (w_movw || w_out)) || (w_mem && w_store);
    assign REG_WE         = w_ex && w_movw;
    assign RAM_RE         = w_mem && w_loada;
    assign RAM_WE         = w_mem && w_store;
    assign RAM_ADDR_EN    = (w_ex && (w_loada || w_store)) || w_mem;
    assign ALU_EN         = w_ex && w_alu;
    assign ALU_OP         = (w_ex && w_alu) ? ALU_OP_W'(w_op[2:0]) : '0;
    assign PC_LOAD        = w_ex && w_take;
    assign PC_EN          = w_done && !(w_ex && w_take);
    assign ROM_TO_DATABUS = w_ex && (w_ldi || w_take);
    assign IN_TO_DATABUS  = w_ex && w_in;
    assign OUT_EN         = w_ex && w_out;

    // state sequencing, IR latch in FETCH, sticky illegal flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_opcode  <= '0;
            r_operand <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_opcode  <= instr_opcode;
                    r_operand <= instr_operand;
                    r_state   <= S_DECODE;
                end
                S_DECODE: r_state <= S_EXEC;
                S_EXEC:   r_state <= w_hlt ? S_HALTED : (w_loada || w_store) ? S_MEM : w_ret;
                S_MEM:    r_state <= mem_ready ? w_ret : S_MEM;
                S_HALTED: r_state <= S_HALTED;
`ifdef SINGLE_STEP_EN
                S_STEP_WAIT: r_state <= step_req ? S_FETCH : S_STEP_WAIT;
`endif
                default:  r_state <= S_FETCH;
            endcase
            r_illegal <= r_illegal || (w_ex && !w_legal);
        end
    end

`ifdef SINGLE_STEP_EN
    logic r_stepped;
    assign stepped = r_stepped;
    // one-cycle pulse as each instruction completes
    always_ff @(posedge clk) begin
        if (rst) r_stepped <= 1'b0;
        else     r_stepped <= w_done;
    end
`endif
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: table-driven EXEC strobe checks plus reset, memory-wait, halt and illegal sequences
module tb_control_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] instr_opcode = '0;
    logic [7:0] instr_operand = '0;
    logic       zeroF = 1'b0, carryF = 1'b0, mem_ready = 1'b0;
    logic [7:0] operand_q;
    logic [2:0] REG_SEL;
    logic [3:0] ALU_OP;
    logic WREG_WE, WREG_RE, REG_WE, RAM_RE, RAM_WE, RAM_ADDR_EN, ALU_EN;
    logic PC_LOAD, PC_EN, ROM_TO_DATABUS, IN_TO_DATABUS, OUT_EN, HALT, ILLEGAL;

    int n_cmp = 0;
    int n_fail = 0;

    localparam logic [12:0] B_WWE = 13'h1000, B_WRE = 13'h0800, B_RWE = 13'h0400, B_RRE = 13'h0200,
                            B_RWR = 13'h0100, B_RAE = 13'h0080, B_AEN = 13'h0040, B_PLD = 13'h0020,
                            B_PEN = 13'h0010, B_ROM = 13'h0008, B_IN  = 13'h0004, B_OUT = 13'h0002,
                            B_HLT = 13'h0001;

    control_sequencer dut (
        .clk(clk), .rst(rst), .instr_opcode(instr_opcode), .instr_operand(instr_operand),
        .zeroF(zeroF), .carryF(carryF), .mem_ready(mem_ready), .operand_q(operand_q),
        .WREG_WE(WREG_WE), .WREG_RE(WREG_RE), .REG_WE(REG_WE), .REG_SEL(REG_SEL),
        .RAM_RE(RAM_RE), .RAM_WE(RAM_WE), .RAM_ADDR_EN(RAM_ADDR_EN), .ALU_OP(ALU_OP),
        .ALU_EN(ALU_EN), .PC_LOAD(PC_LOAD), .PC_EN(PC_EN), .ROM_TO_DATABUS(ROM_TO_DATABUS),
        .IN_TO_DATABUS(IN_TO_DATABUS), .OUT_EN(OUT_EN), .HALT(HALT), .ILLEGAL(ILLEGAL)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] strb();
        return {WREG_WE, WREG_RE, REG_WE, RAM_RE, RAM_WE, RAM_ADDR_EN, ALU_EN,
                PC_LOAD, PC_EN, ROM_TO_DATABUS, IN_TO_DATABUS, OUT_EN, HALT};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // entered just after a negedge with the DUT in FETCH; returns just after the EXEC negedge
    task automatic run_instr(input logic [4:0] op, input logic [7:0] opd, input logic z, input logic c);
        instr_opcode = op; instr_operand = opd; zeroF = ~z; carryF = ~c; #1;
        chk("fetch_strb", strb(), 0);
        @(negedge clk); instr_opcode = 5'b11111; instr_operand = ~opd; #1;
        chk("decode_strb", strb(), 0);
        chk("decode_alu", ALU_OP, 0);
        @(negedge clk); zeroF = z; carryF = c; instr_opcode = 5'b10011; #1;
        chk("exec_opq", operand_q, opd);
        chk("exec_regsel", REG_SEL, opd[2:0]);
    endtask

    typedef struct packed {
        logic [4:0]  op;
        logic [7:0]  opd;
        logic        z;
        logic        c;
        logic [12:0] exp;
        logic [3:0]  alu;
        logic        ill;
    } vec_t;
    vec_t vt[21];

    initial begin
        logic exp_ill;
        vt[0]  = '{5'b00000, 8'h11, 1'b0, 1'b0, B_PEN,               4'd0, 1'b0};
        vt[1]  = '{5'b00001, 8'h03, 1'b0, 1'b0, B_WWE|B_ROM|B_PEN,   4'd0, 1'b0};
        vt[2]  = '{5'b00100, 8'h05, 1'b0, 1'b0, B_WWE|B_PEN,         4'd0, 1'b0};
        vt[3]  = '{5'b00101, 8'h06, 1'b0, 1'b0, B_WRE|B_RWE|B_PEN,   4'd0, 1'b0};
        vt[4]  = '{5'b01101, 8'h21, 1'b0, 1'b0, B_WWE|B_AEN|B_PEN,   4'd5, 1'b0};
        vt[5]  = '{5'b01000, 8'h22, 1'b0, 1'b0, B_WWE|B_AEN|B_PEN,   4'd0, 1'b0};
        vt[6]  = '{5'b01111, 8'h23, 1'b1, 1'b1, B_WWE|B_AEN|B_PEN,   4'd7, 1'b0};
        vt[7]  = '{5'b10000, 8'h40, 1'b0, 1'b0, B_PLD|B_ROM,         4'd0, 1'b0};
        vt[8]  = '{5'b10001, 8'h41, 1'b0, 1'b0, B_PEN,               4'd0, 1'b0};
        vt[9]  = '{5'b10001, 8'h42, 1'b1, 1'b0, B_PLD|B_ROM,         4'd0, 1'b0};
        vt[10] = '{5'b10001, 8'h43, 1'b0, 1'b1, B_PEN,               4'd0, 1'b0};
        vt[11] = '{5'b10010, 8'h44, 1'b0, 1'b0, B_PEN,               4'd0, 1'b0};
        vt[12] = '{5'b10010, 8'h45, 1'b0, 1'b1, B_PLD|B_ROM,         4'd0, 1'b0};
        vt[13] = '{5'b10010, 8'h46, 1'b1, 1'b0, B_PEN,               4'd0, 1'b0};
        vt[14] = '{5'b10100, 8'h57, 1'b0, 1'b0, B_WWE|B_IN|B_PEN,    4'd0, 1'b0};
        vt[15] = '{5'b10101, 8'h58, 1'b0, 1'b0, B_WRE|B_OUT|B_PEN,   4'd0, 1'b0};
        vt[16] = '{5'b00000, 8'h59, 1'b0, 1'b0, B_PEN,               4'd0, 1'b0};
        vt[17] = '{5'b00110, 8'h5a, 1'b0, 1'b0, B_PEN,               4'd0, 1'b1};
        vt[18] = '{5'b00000, 8'h5b, 1'b0, 1'b0, B_PEN,               4'd0, 1'b0};
        vt[19] = '{5'b11111, 8'h5c, 1'b0, 1'b0, B_PEN,               4'd0, 1'b1};
        vt[20] = '{5'b00000, 8'h5d, 1'b0, 1'b0, B_PEN,               4'd0, 1'b0};

        // reset held for two edges with LOADI 03 on the ROM
        rst = 1'b1; instr_opcode = 5'b00001; instr_operand = 8'h03;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_strb", strb(), 0);
        chk("rst_opq", operand_q, 0);
        chk("rst_ill", ILLEGAL, 0);
        chk("rst_alu", ALU_OP, 0);
        rst = 1'b0;
        run_instr(5'b00001, 8'h03, 1'b0, 1'b0);
        chk("rel_exec", strb(), B_WWE|B_ROM|B_PEN);
        @(negedge clk);

        // table: one instruction per record
        exp_ill = 1'b0;
        for (int i = 0; i < 21; i++) begin
            mem_ready = vt[i].op[0];
            run_instr(vt[i].op, vt[i].opd, vt[i].z, vt[i].c);
            chk($sformatf("vec%0d_strb", i), strb(), vt[i].exp);
            chk($sformatf("vec%0d_alu", i), ALU_OP, vt[i].alu);
            exp_ill = exp_ill | vt[i].ill;
            @(negedge clk); #1;
            chk($sformatf("vec%0d_ill", i), ILLEGAL, exp_ill);
            chk($sformatf("vec%0d_next", i), strb(), 0);
        end

        // LOADA with three wait cycles; mem_ready high before MEM must be ignored
        mem_ready = 1'b1;
        run_instr(5'b00010, 8'h7c, 1'b0, 1'b0);
        chk("lda_exec", strb(), B_RAE);
        @(negedge clk); mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("lda_wait%0d", k), strb(), B_RRE|B_RAE);
            @(negedge clk);
        end
        mem_ready = 1'b1; #1;
        chk("lda_done", strb(), B_RRE|B_RAE|B_WWE|B_PEN);
        @(negedge clk); mem_ready = 1'b0;
        run_instr(5'b00000, 8'h01, 1'b0, 1'b0);
        chk("lda_after", strb(), B_PEN);
        @(negedge clk);

        // STORE with one wait cycle
        run_instr(5'b00011, 8'h3d, 1'b0, 1'b0);
        chk("sta_exec", strb(), B_RAE);
        @(negedge clk); #1;
        chk("sta_wait", strb(), B_RWR|B_WRE|B_RAE);
        @(negedge clk); mem_ready = 1'b1; #1;
        chk("sta_done", strb(), B_RWR|B_WRE|B_RAE|B_PEN);
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("sta_fetch", strb(), 0);

        // reset in the middle of a MEM wait also clears sticky ILLEGAL
        run_instr(5'b00010, 8'h99, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk); #1;
        chk("rmem_wait", strb(), B_RRE|B_RAE);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rmem_strb", strb(), 0);
        chk("rmem_ill", ILLEGAL, 0);
        chk("rmem_opq", operand_q, 0);
        rst = 1'b0;

        // HLT then arbitrary ROM traffic
        run_instr(5'b10011, 8'h00, 1'b0, 1'b0);
        chk("hlt_exec", strb(), 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            instr_opcode = 5'($urandom); instr_operand = 8'($urandom);
            zeroF = 1'($urandom); carryF = 1'($urandom); mem_ready = 1'($urandom); #1;
            chk($sformatf("halted%0d", k), strb(), B_HLT);
        end
        rst = 1'b1;
        @(negedge clk); #1;
        chk("hlt_rst", strb(), 0);
        rst = 1'b0; mem_ready = 1'b0;
        run_instr(5'b00100, 8'h0e, 1'b0, 1'b0);
        chk("hlt_resume", strb(), B_WWE|B_PEN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
